// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: two requester ports, shared response and the memory command port.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    // Requester 0 (core)
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic          m0_err;

    // Requester 1 (loader/DMA)
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic          m1_err;

    // Shared response and ownership
    logic [DW-1:0] rdata;
    logic [1:0]    grant;

    // Memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata, mem_ready,
        input  m0_ack, m0_err, m1_ack, m1_err,
        input  rdata, grant,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata, mem_ready,
        output m0_ack, m0_err, m1_ack, m1_err,
        output rdata, grant,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// One access in flight at a time, bounded by a BUSY-cycle timeout that reports err with the ack.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic [1:0]    grant_q, grant_d;
    logic          last_m1_q, last_m1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    err_q, err_d;

    logic          any_req_c;
    logic          pick_m1_c;
    logic          timeout_c;
    logic          done_c;

    // m1 wins when it is alone, or on a tie when m0 was the last owner
    assign any_req_c = bus.m0_req | bus.m1_req;
    assign pick_m1_c = bus.m1_req & (~bus.m0_req | ~last_m1_q);
    assign timeout_c = (cnt_q == LAST_CNT);
    assign done_c    = bus.mem_ready | timeout_c;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done_c) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        grant_d     = grant_q;
        last_m1_d   = last_m1_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    grant_d   = pick_m1_c ? 2'b10 : 2'b01;
                    last_m1_d = pick_m1_c;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    if (pick_m1_c) begin
                        mem_we_d    = bus.m1_we;
                        mem_addr_d  = bus.m1_addr;
                        mem_wdata_d = bus.m1_wdata;
                    end else begin
                        mem_we_d    = bus.m0_we;
                        mem_addr_d  = bus.m0_addr;
                        mem_wdata_d = bus.m0_wdata;
                    end
                end
            end
            BUSY: begin
                // A ready on the last counted cycle still completes normally
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    ack_d     = grant_q;
                    rdata_d   = mem_we_q ? '0 : bus.mem_rdata;
                end else if (timeout_c) begin
                    mem_req_d = 1'b0;
                    ack_d     = grant_q;
                    err_d     = grant_q;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                grant_d = 2'b00;
            end
            default: begin
                grant_d   = 2'b00;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= 2'b00;
            last_m1_q   <= 1'b1;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            grant_q     <= grant_d;
            last_m1_q   <= last_m1_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected responses, a monitor checks them.
// Memory ready delay is encoded in addr[4:0]; read data is a fixed function of the address.
module tb_mem_arbiter;

    localparam int unsigned AW         = 32;
    localparam int unsigned DW         = 32;
    localparam int unsigned TIMEOUT    = 16;
    localparam int          WAIT_LIMIT = 400;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            busy;
    } txn_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    bit   tie_phase = 1'b0;
    txn_t q0[$];
    txn_t q1[$];

    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic [1:0]    ack_v;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.m0_req   = req0;
    assign bus.m0_we    = we0;
    assign bus.m0_addr  = addr0;
    assign bus.m0_wdata = wd0;
    assign bus.m1_req   = req1;
    assign bus.m1_we    = we1;
    assign bus.m1_addr  = addr1;
    assign bus.m1_wdata = wd1;
    assign ack_v        = {bus.m1_ack, bus.m0_ack};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == AW'(32'h40)) return DW'(32'hDEAD_BEEF);
        return DW'(a * 32'h9E37_79B1) ^ DW'(32'h5A5A_0F0F);
    endfunction

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i == 0) begin
            req0 = r; we0 = w; addr0 = a; wd0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wd1 = d;
        end
    endtask

    // One requester: issues ntx accesses, scrambles its command once granted, waits for ack
    task automatic run_master(input int i, input int ntx, input bit hold,
                              input int idle_lo, input int idle_hi,
                              input int fixed_d, input logic fixed_we,
                              input logic [AW-1:0] base, input bit chk_lat);
        for (int n = 0; n < ntx; n++) begin
            txn_t t;
            int   d;
            int   sel;
            int   waited;
            bit   seen_grant;
            if (!hold || n == 0) begin
                set_req(i, 1'b0, 1'b0, '0, '0);
                repeat ($urandom_range(idle_hi, idle_lo)) @(negedge clk);
            end
            if (fixed_d >= 0) begin
                d      = fixed_d;
                t.we   = fixed_we;
                t.addr = base | AW'(d);
            end else begin
                sel = int'($urandom_range(7, 0));
                case (sel)
                    0:       d = 0;
                    1:       d = int'(TIMEOUT) - 1;
                    2:       d = int'(TIMEOUT);
                    3:       d = int'($urandom_range(31, TIMEOUT + 1));
                    default: d = int'($urandom_range(TIMEOUT - 2, 0));
                endcase
                t.we   = 1'($urandom_range(1, 0));
                t.addr = (AW'($urandom) & ~AW'(31)) | AW'(d);
            end
            t.wdata = DW'($urandom);
            t.err   = (d >= int'(TIMEOUT));
            t.rdata = (t.we || t.err) ? '0 : mem_fn(t.addr);
            t.busy  = t.err ? int'(TIMEOUT) : d + 1;
            if (i == 0) q0.push_back(t); else q1.push_back(t);
            set_req(i, 1'b1, t.we, t.addr, t.wdata);
            waited     = 0;
            seen_grant = 1'b0;
            forever begin
                @(negedge clk);
                waited++;
                if (ack_v[i]) break;
                if (bus.grant[i] && !seen_grant) begin
                    seen_grant = 1'b1;
                    set_req(i, 1'b1, ~t.we, ~t.addr, ~t.wdata);
                end
                if (waited >= WAIT_LIMIT) break;
            end
            check($sformatf("m%0d_ack_wait", i), 64'(waited < WAIT_LIMIT), 64'd1);
            if (waited >= WAIT_LIMIT) begin
                set_req(i, 1'b0, 1'b0, '0, '0);
                return;
            end
            if (chk_lat)
                check($sformatf("m%0d_latency", i), 64'(waited),
                      64'(2 + ((d < int'(TIMEOUT) - 1) ? d : int'(TIMEOUT) - 1)));
        end
        set_req(i, 1'b0, 1'b0, '0, '0);
    endtask

    // Memory model: ready on BUSY cycle addr[4:0]; noise on ready/rdata whenever not addressed
    initial begin : memory
        int k;
        k = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                bus.mem_ready = (k == int'(bus.mem_addr[4:0]));
                bus.mem_rdata = bus.mem_ready ? mem_fn(bus.mem_addr) : DW'($urandom);
                k++;
            end else begin
                k = 0;
                bus.mem_ready = 1'($urandom_range(1, 0));
                bus.mem_rdata = DW'($urandom);
            end
        end
    end

    // Monitor: round-robin reference, command stability, response scoreboard
    initial begin : monitor
        logic [1:0] req_prev, prev_grant;
        bit         prev_mem_req, prev_ack, have_tie_ack, have_t;
        int         last_owner, busy_cycles, cycle, last_ack_cycle, owner;
        txn_t       t;
        req_prev = 2'b00; prev_grant = 2'b00; prev_mem_req = 0; prev_ack = 0;
        have_tie_ack = 0; last_owner = 1; busy_cycles = 0; cycle = 0; last_ack_cycle = 0;
        forever begin
            @(negedge clk);
            #2;
            cycle++;
            if (reset_n !== 1'b1) begin
                last_owner = 1; busy_cycles = 0; req_prev = 2'b00; prev_grant = 2'b00;
                prev_mem_req = 0; prev_ack = 0; have_tie_ack = 0;
                continue;
            end
            if (bus.mem_req && !prev_mem_req) begin
                check("idle_before_grant", 64'(prev_grant), 64'd0);
                case (req_prev)
                    2'b01:   owner = 0;
                    2'b10:   owner = 1;
                    2'b11:   owner = 1 - last_owner;
                    default: owner = -1;
                endcase
                check("rr_grant", 64'(bus.grant), (owner < 0) ? 64'd0 : 64'(1 << owner));
                if (owner >= 0) last_owner = owner;
                busy_cycles = 0;
            end
            if (bus.mem_req) begin
                busy_cycles++;
                have_t = 1'b0;
                if (bus.grant == 2'b01 && q0.size() > 0) begin t = q0[0]; have_t = 1'b1; end
                if (bus.grant == 2'b10 && q1.size() > 0) begin t = q1[0]; have_t = 1'b1; end
                check("busy_owner", 64'(have_t), 64'd1);
                if (have_t) begin
                    check("cmd_we",    64'(bus.mem_we),    64'(t.we));
                    check("cmd_addr",  64'(bus.mem_addr),  64'(t.addr));
                    check("cmd_wdata", 64'(bus.mem_wdata), 64'(t.wdata));
                end
            end
            check("err_without_ack", 64'({bus.m1_err, bus.m0_err} & ~ack_v), 64'd0);
            if (ack_v != 2'b00) begin
                check("ack_owner", 64'(ack_v), 64'(bus.grant));
                check("ack_after_busy", 64'({prev_mem_req, bus.mem_req}), 64'b10);
                have_t = 1'b0;
                if (ack_v == 2'b01 && q0.size() > 0) begin t = q0.pop_front(); have_t = 1'b1; end
                if (ack_v == 2'b10 && q1.size() > 0) begin t = q1.pop_front(); have_t = 1'b1; end
                check("ack_expected", 64'(have_t), 64'd1);
                if (have_t) begin
                    check("resp_rdata", 64'(bus.rdata), 64'(t.rdata));
                    check("resp_err", 64'((ack_v == 2'b01) ? bus.m0_err : bus.m1_err), 64'(t.err));
                    check("busy_cycles", 64'(busy_cycles), 64'(t.busy));
                end
                if (tie_phase) begin
                    if (have_tie_ack) check("tie_ack_gap", 64'(cycle - last_ack_cycle), 64'd3);
                    have_tie_ack   = 1'b1;
                    last_ack_cycle = cycle;
                end
            end
            if (!tie_phase) have_tie_ack = 1'b0;
            if (prev_ack) check("idle_after_ack", 64'({bus.grant, bus.mem_req}), 64'd0);
            prev_ack     = (ack_v != 2'b00);
            prev_mem_req = bus.mem_req;
            prev_grant   = bus.grant;
            req_prev     = {req1, req0};
        end
    end

    initial begin : main
        txn_t t;
        int   n;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_grant",     64'(bus.grant),     64'd0);
        check("rst_mem_req",   64'(bus.mem_req),   64'd0);
        check("rst_mem_we",    64'(bus.mem_we),    64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rdata",     64'(bus.rdata),     64'd0);
        check("rst_ack_err",   64'({ack_v, bus.m1_err, bus.m0_err}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single read, timeout write, ready on the last BUSY cycle
        run_master(0, 1, 1'b0, 1, 2, 0, 1'b0, AW'(32'h40), 1'b1);
        run_master(1, 1, 1'b0, 1, 2, 20, 1'b1, AW'(32'h2000), 1'b1);
        run_master(0, 1, 1'b0, 1, 2, int'(TIMEOUT) - 1, 1'b0, AW'(32'h3000), 1'b1);

        // Random contention, then back-to-back held requests
        fork
            run_master(0, 40, 1'b0, 0, 3, -1, 1'b0, '0, 1'b0);
            run_master(1, 40, 1'b0, 0, 3, -1, 1'b0, '0, 1'b0);
        join
        fork
            run_master(0, 25, 1'b1, 0, 3, -1, 1'b0, '0, 1'b0);
            run_master(1, 25, 1'b1, 0, 3, -1, 1'b0, '0, 1'b0);
        join

        // Both requesters held from reset: strict alternation, ack every 3 cycles
        @(negedge clk);
        reset_n   = 1'b0;
        tie_phase = 1'b1;
        fork
            run_master(0, 4, 1'b1, 0, 0, 0, 1'b0, AW'(32'h5000), 1'b0);
            run_master(1, 4, 1'b1, 0, 0, 0, 1'b0, AW'(32'h6000), 1'b0);
            begin
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
            end
        join
        tie_phase = 1'b0;

        // Reset in the middle of an access
        repeat (2) @(negedge clk);
        t.we = 1'b0; t.addr = AW'(32'h1000_0019); t.wdata = DW'(32'h1234_5678);
        t.err = 1'b1; t.rdata = '0; t.busy = int'(TIMEOUT);
        q0.push_back(t);
        set_req(0, 1'b1, t.we, t.addr, t.wdata);
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_busy", 64'(bus.mem_req), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("async_rst_grant",   64'(bus.grant),   64'd0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        q0.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (ack_v != 2'b00) n++;
        end
        check("no_ack_after_reset", 64'(n), 64'd0);

        @(negedge clk);
        #3;
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter TIMEOUT, default 16, maximum BUSY cycles; legal range 2..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 m0_req / m1_req  input  1 each  access request: m0 is the core, m1 is the loader/DMA.
REQ-007 m0_we / m1_we  input  1 each  1 = write, 0 = read.
REQ-008 m0_addr / m1_addr  input  AW each  access address.
REQ-009 m0_wdata / m1_wdata  input  DW each  write data.
REQ-010 m0_ack / m1_ack  output  1 each  one-cycle completion pulse.
REQ-011 m0_err / m1_err  output  1 each  timeout flag, valid only with the matching ack.
REQ-012 rdata  output  DW  registered read data, valid with any ack.
REQ-013 grant  output  2  one-hot owner ({m1,m0}); 00 when idle.
REQ-014 mem_req, mem_we  output  1 each  memory strobe and direction.
REQ-015 mem_addr, mem_wdata  output  AW, DW  registered command to memory.
REQ-016 mem_rdata  input  DW  memory read data.
REQ-017 mem_ready  input  1  memory completion; sampled only while mem_req=1.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-019 In IDLE with no request, the FSM SHALL stay in IDLE with grant=00 and mem_req=0.
REQ-020 In IDLE with exactly one requester high, the arbiter SHALL grant that requester and move to BUSY on the next edge.
REQ-021 In IDLE with both requesters high, the arbiter SHALL grant the requester that is not the last one granted (round-robin).
REQ-022 On every grant, the last-grant pointer SHALL update to the new owner.
REQ-023 On the grant edge, the owner's we, addr and wdata SHALL be latched into mem_we, mem_addr and mem_wdata; later changes on requester inputs SHALL be ignored until the next grant.
REQ-024 In BUSY, mem_req SHALL be 1 and grant SHALL show the owner.
REQ-025 In BUSY with mem_ready=1, mem_rdata SHALL be captured into rdata (0 for writes), err SHALL be cleared and the FSM SHALL move to RESP.
REQ-026 The BUSY cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-027 When the counter reaches TIMEOUT-1 with mem_ready=0, the FSM SHALL move to RESP with rdata=0 and err=1.
REQ-028 mem_ready=1 in the same cycle as the timeout count SHALL complete normally with err=0.
REQ-029 In RESP, the owner's ack SHALL be 1 for exactly one cycle, mem_req SHALL be 0 and the FSM SHALL return to IDLE.
REQ-030 grant SHALL remain valid through RESP.
REQ-031 Minimum latency SHALL be: req sampled in IDLE at cycle N, mem_req high in cycle N+1, ack at cycle N+2 when mem_ready is 1 in N+1.
REQ-032 A requester holding req high after its ack SHALL be treated as a new request in IDLE and arbitrated normally.
REQ-033 Requests arriving during BUSY or RESP SHALL wait; they SHALL not be dropped and SHALL not preempt the current owner.
REQ-034 The non-owner's ack and err SHALL stay 0 at all times.
REQ-035 mem_ready outside BUSY SHALL be ignored.

Reset
REQ-036 While reset_n=0, the FSM SHALL be forced to IDLE immediately, with no clock required.
REQ-037 Reset values: grant=00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, all ack and err=0, counter=0, last-grant pointer=m1 (so m0 wins the first tie).
REQ-038 Reset during BUSY or RESP SHALL abandon the transaction with no ack issued.
REQ-039 Deassertion of reset_n SHALL take effect at the next rising clk edge.

Verification
REQ-040 Single read: m0_req=1, we=0, addr=0x40; mem_ready=1 first BUSY cycle, mem_rdata=0xDEADBEEF -> mem_req one cycle; m0_ack at cycle 2 with rdata=0xDEADBEEF and err=0.
REQ-041 Tie round-robin: both requesters held high continuously from reset, ready=1 each BUSY cycle -> grant order m0,m1,m0,m1, acks every 3 cycles.
REQ-042 Timeout: m1 write, mem_ready held 0 -> mem_req high 16 cycles, m1_ack with m1_err=1 and rdata=0; FSM back in IDLE.
REQ-043 Ready on the boundary: mem_ready=1 in BUSY cycle 16 -> err=0 and data captured.
REQ-044 Command stability: m0_addr changed mid-BUSY -> mem_addr keeps the latched value.
REQ-045 Reset mid-access: reset_n=0 in BUSY -> mem_req=0 and grant=00 without a clock edge; no ack after release.
